demux16_deserializer: RTL and testbench

//   Serial-to-parallel collector: the inverse of the 16:1 select tree.
//   A bit-index counter acts as the demux select. Each accepted serial bit is written to word[idx].
//   A completed word is handed to a single-entry output register with a valid/ready handshake.

---
 rtl/demux16_deserializer.sv | 116 +++++++++++
 tb/tb_demux16_deserializer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux16_deserializer.sv
// Serial-to-parallel collector: LSB-first bits are demuxed into a word by a bit-index
// counter and handed to a single-entry valid/ready output slot. Optional: DEMUX16_PARITY_EN.
module demux16_deserializer #(
    parameter int unsigned WIDTH = 16,
`ifdef DEMUX16_PARITY_EN
    localparam int unsigned NBITS = WIDTH + 1,
`else
    localparam int unsigned NBITS = WIDTH,
`endif
    localparam int unsigned SEL_W = $clog2(NBITS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    input  logic             in_bit,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_perr,
    output logic [SEL_W-1:0] fill_cnt
);

    localparam logic [SEL_W-1:0] LAST = SEL_W'(NBITS - 1);

    logic [SEL_W-1:0] r_idx, w_idx_nxt;
    logic [NBITS-1:0] r_shreg, w_shreg_nxt, w_word;
    logic             r_pending, w_pending_nxt;
    logic             r_out_valid, w_out_valid_nxt;
    logic [WIDTH-1:0] r_out_data, w_out_data_nxt;
    logic             w_load;
    logic             w_accept, w_last, w_slot_free;

    // Next-state: collect bits, complete words, move them into the output slot
    always_comb begin
        w_idx_nxt       = r_idx;
        w_shreg_nxt     = r_shreg;
        w_pending_nxt   = r_pending;
        w_out_valid_nxt = r_out_valid;
        w_out_data_nxt  = r_out_data;
        w_load          = 1'b0;

        w_slot_free = ~r_out_valid | out_ready;
        w_accept    = in_valid & ~r_pending & ~clr;
        w_last      = w_accept & (r_idx == LAST);

        w_word = r_shreg;
        if (w_accept) begin
            w_word[r_idx] = in_bit;
        end

        if (r_out_valid & out_ready) begin
            w_out_valid_nxt = 1'b0;
        end

        if (clr) begin
            // A pending word is dropped; the output slot is left alone
            w_idx_nxt     = '0;
            w_shreg_nxt   = '0;
            w_pending_nxt = 1'b0;
        end else begin
            w_shreg_nxt = w_word;
            if (w_accept) begin
                w_idx_nxt = w_last ? '0 : r_idx + SEL_W'(1);
            end
            if ((w_last | r_pending) & w_slot_free) begin
                w_load          = 1'b1;
                w_out_valid_nxt = 1'b1;
                w_out_data_nxt  = w_word[WIDTH-1:0];
                w_pending_nxt   = 1'b0;
            end else if (w_last) begin
                w_pending_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx       <= '0;
            r_shreg     <= '0;
            r_pending   <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            r_idx       <= w_idx_nxt;
            r_shreg     <= w_shreg_nxt;
            r_pending   <= w_pending_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_data  <= w_out_data_nxt;
        end
    end

`ifdef DEMUX16_PARITY_EN
    logic r_out_perr;

    // Even parity over data plus parity bit, registered alongside the data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_perr <= 1'b0;
        end else if (w_load) begin
            r_out_perr <= ^w_word;
        end
    end

    assign out_perr = r_out_perr;
`else
    assign out_perr = 1'b0;
`endif

    assign in_ready  = ~r_pending;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign fill_cnt  = r_idx;

endmodule

// File: tb/tb_demux16_deserializer.sv
// Self-checking bench for demux16_deserializer: directed scenarios plus random traffic
// compared every cycle against a queue-based model of the collector.
`timescale 1ns/1ps
module tb_demux16_deserializer;

    localparam int unsigned WIDTH = 16;
`ifdef DEMUX16_PARITY_EN
    localparam int unsigned NB = WIDTH + 1;
`else
    localparam int unsigned NB = WIDTH;
`endif
    localparam int unsigned SEL_W = $clog2(NB);

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             clr = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_bit = 1'b0;
    logic             out_ready = 1'b0;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_perr;
    logic [SEL_W-1:0] fill_cnt;

    int n_chk = 0;
    int n_err = 0;

    demux16_deserializer #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(in_valid), .in_bit(in_bit), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_perr(out_perr), .fill_cnt(fill_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: bits collected so far, completed words waiting, output slot
    bit              bits_q[$];
    logic [NB-1:0]   pend_q[$];
    logic            m_ov = 1'b0;
    logic [WIDTH-1:0] m_od = '0;
    logic            m_perr = 1'b0;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            bits_q.delete();
            pend_q.delete();
            m_ov = 1'b0; m_od = '0; m_perr = 1'b0;
        end else begin
            bit free;
            logic [NB-1:0] w;
            free = !m_ov || out_ready;
            if (m_ov && out_ready) m_ov = 1'b0;
            if (clr) begin
                bits_q.delete();
                pend_q.delete();
            end else begin
                if (in_valid && pend_q.size() == 0) begin
                    bits_q.push_back(in_bit);
                    if (bits_q.size() == NB) begin
                        w = '0;
                        foreach (bits_q[i]) w[i] = bits_q[i];
                        pend_q.push_back(w);
                        bits_q.delete();
                    end
                end
                if (free && pend_q.size() != 0) begin
                    w = pend_q.pop_front();
                    m_ov = 1'b1;
                    m_od = w[WIDTH-1:0];
`ifdef DEMUX16_PARITY_EN
                    m_perr = ^w;
`else
                    m_perr = 1'b0;
`endif
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    initial forever begin
        @(negedge clk);
        n_chk++;
        if (out_valid !== m_ov) begin
            n_err++; $display("FAIL out_valid: got %0b expected %0b at %0t", out_valid, m_ov, $time);
        end
        n_chk++;
        if (m_ov && out_data !== m_od) begin
            n_err++; $display("FAIL out_data: got %h expected %h at %0t", out_data, m_od, $time);
        end
        n_chk++;
        if (m_ov && out_perr !== m_perr) begin
            n_err++; $display("FAIL out_perr: got %0b expected %0b at %0t", out_perr, m_perr, $time);
        end
        n_chk++;
        if (in_ready !== (pend_q.size() == 0)) begin
            n_err++; $display("FAIL in_ready: got %0b expected %0b at %0t", in_ready, pend_q.size() == 0, $time);
        end
        n_chk++;
        if (int'(fill_cnt) != bits_q.size()) begin
            n_err++; $display("FAIL fill_cnt: got %0d expected %0d at %0t", fill_cnt, bits_q.size(), $time);
        end
    end

    // Stream recorder: out_valid pulse cycles and in_ready drops while enabled
    bit rec = 1'b0;
    int cyc = 0;
    int pulses[$];
    int rdy_drops = 0;
    initial forever begin
        @(negedge clk);
        cyc++;
        if (rec && out_valid) pulses.push_back(cyc);
        if (rec && !in_ready) rdy_drops++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        in_valid = 1'b1;
        in_bit   = b;
        tick();
        in_valid = 1'b0;
    endtask

    // Sends a word LSB first; with parity, appends a correct or corrupted parity bit
    task automatic send_word(input logic [WIDTH-1:0] d, input bit good_par);
        logic [WIDTH-1:0] dv;
        dv = d;
        for (int i = 0; i < int'(WIDTH); i++) send_bit(dv[i]);
`ifdef DEMUX16_PARITY_EN
        send_bit(good_par ? ^dv : ~(^dv));
`else
        if (!good_par) $display("note: parity disabled, bad parity request ignored");
`endif
    endtask

    initial begin
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Reset mid-word discards the partial word
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        chk("pre_reset_fill", 64'(fill_cnt), 64'd5);
        rst_n = 1'b0;
        #2;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_fill_cnt", 64'(fill_cnt), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        send_word(16'h5A5A, 1'b1);
        chk("after_rst_word", 64'(out_data), 64'h5A5A);

        // Single word, one cycle latency
        tick();
        send_word(16'hA5C3, 1'b1);
        chk("a5c3_valid", 64'(out_valid), 64'd1);
        chk("a5c3_data", 64'(out_data), 64'hA5C3);
        chk("a5c3_perr", 64'(out_perr), 64'd0);
        tick();
        chk("a5c3_consumed", 64'(out_valid), 64'd0);

        // Backpressure: second word waits as pending
        out_ready = 1'b0;
        send_word(16'h1234, 1'b1);
        send_word(16'hFFFF, 1'b1);
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        chk("bp_data_held", 64'(out_data), 64'h1234);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_next_data", 64'(out_data), 64'hFFFF);
        chk("bp_next_valid", 64'(out_valid), 64'd1);
        chk("bp_next_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        tick();

        // clr aborts a partial word; clr beats a same-cycle bit
        for (int i = 0; i < 7; i++) send_bit(1'($urandom_range(0, 1)));
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_fill", 64'(fill_cnt), 64'd0);
        clr = 1'b1;
        send_bit(1'b1);
        clr = 1'b0;
        chk("clr_vs_bit_fill", 64'(fill_cnt), 64'd0);
        send_word(16'h00FF, 1'b1);
        chk("clr_word_data", 64'(out_data), 64'h00FF);
        tick();

`ifdef DEMUX16_PARITY_EN
        send_word(16'h0001, 1'b1);
        chk("par_good_perr", 64'(out_perr), 64'd0);
        send_word(16'h0001, 1'b0);
        chk("par_bad_perr", 64'(out_perr), 64'd1);
        chk("par_bad_data", 64'(out_data), 64'h0001);
        tick();
`else
        send_word(16'h0001, 1'b1);
        chk("noparity_perr", 64'(out_perr), 64'd0);
        tick();
`endif

        // Continuous stream of three words
        pulses.delete();
        rdy_drops = 0;
        rec = 1'b1;
        send_word(16'h1111, 1'b1);
        send_word(16'h2222, 1'b1);
        send_word(16'h3333, 1'b1);
        tick(); tick();
        rec = 1'b0;
        chk("stream_pulses", 64'(pulses.size()), 64'd3);
        chk("stream_ready_drops", 64'(rdy_drops), 64'd0);
        if (pulses.size() == 3) begin
            chk("stream_gap1", 64'(pulses[1] - pulses[0]), 64'(NB));
            chk("stream_gap2", 64'(pulses[2] - pulses[1]), 64'(NB));
        end

        // Random traffic against the model
        for (int n = 0; n < 4000; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_bit    = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            clr       = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 999) == 0) begin
                rst_n = 1'b0;
                tick();
                rst_n = 1'b1;
            end
            tick();
        end
        in_valid = 1'b0;
        clr = 1'b0;
        out_ready = 1'b1;
        tick(); tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
